// File: rtl/reg_seq_defs.sv
// Shared state, opcode and write-select encodings
// for the reg_seq instruction sequencer.
package reg_seq_defs;

  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    DECODE = 3'd1,
    GET_A  = 3'd2,
    GET_B  = 3'd3,
    ALU    = 3'd4,
    STATUS = 3'd5,
    WB_REG = 3'd6,
    WB_IMM = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_CMP   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_MVN   = 2'b11;
  localparam logic [1:0] OP_MOVI  = 2'b10;
  localparam logic [1:0] OP_MOVR  = 2'b00;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/reg_seq_out.sv
// State-to-control decoder: Moore outputs from
// the registered sequencer state.
module reg_seq_out
  import reg_seq_defs::*;
#(
  parameter int RW = 3,
  parameter int VW = 2
) (
  input  state_t        i_state,
  input  logic [2:0]    i_opcode,
  input  logic [1:0]    i_op,
  input  logic [RW-1:0] i_rn,
  input  logic [RW-1:0] i_rd,
  input  logic [RW-1:0] i_rm,
  output logic          o_w,
  output logic [RW-1:0] o_readnum,
  output logic [RW-1:0] o_writenum,
  output logic          o_write,
  output logic          o_loada,
  output logic          o_loadb,
  output logic          o_loadc,
  output logic          o_loads,
  output logic          o_asel,
  output logic [VW-1:0] o_vsel
);

  logic w_zero_a;

  // MOV Rd,Rm and MVN pass only the B operand
  assign w_zero_a = (i_opcode == OPC_MOV) ||
                    ((i_opcode == OPC_ALU) &&
                     (i_op == OP_MVN));

  // One control pattern per state; all idle by default
  always_comb begin
    o_w        = 1'b0;
    o_readnum  = '0;
    o_writenum = '0;
    o_write    = 1'b0;
    o_loada    = 1'b0;
    o_loadb    = 1'b0;
    o_loadc    = 1'b0;
    o_loads    = 1'b0;
    o_asel     = 1'b0;
    o_vsel     = VW'(VSEL_C);
    case (i_state)
      WAIT:   o_w = 1'b1;
      DECODE: ;
      GET_A: begin
        o_readnum = i_rn;
        o_loada   = 1'b1;
      end
      GET_B: begin
        o_readnum = i_rm;
        o_loadb   = 1'b1;
      end
      ALU: begin
        o_loadc = 1'b1;
        o_asel  = w_zero_a;
      end
      STATUS: o_loads = 1'b1;
      WB_REG: begin
        o_writenum = i_rd;
        o_vsel     = VW'(VSEL_C);
        o_write    = 1'b1;
      end
      WB_IMM: begin
        o_writenum = i_rn;
        o_vsel     = VW'(VSEL_IMM);
        o_write    = 1'b1;
      end
      default: o_w = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_seq.sv
// Multi-cycle MOV/ALU sequencer: state register
// and next-state logic; outputs via reg_seq_out.
module reg_seq
  import reg_seq_defs::*;
#(
  parameter int RW = 3,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic [2:0]    opcode,
  input  logic [1:0]    op,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rm,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic [VW-1:0] vsel
);

  state_t r_state;
  logic   w_is_cmp;

  assign w_is_cmp = (opcode == OPC_ALU) &&
                    (op == OP_CMP);

  // Sequencer state register with next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
    end else begin
      case (r_state)
        WAIT:
          if (s) r_state <= DECODE;
        DECODE:
          case ({opcode, op})
            {OPC_MOV, OP_MOVI}: r_state <= WB_IMM;
            {OPC_MOV, OP_MOVR}: r_state <= GET_B;
            {OPC_ALU, OP_ADD}:  r_state <= GET_A;
            {OPC_ALU, OP_CMP}:  r_state <= GET_A;
            {OPC_ALU, OP_AND}:  r_state <= GET_A;
            {OPC_ALU, OP_MVN}:  r_state <= GET_B;
            default:            r_state <= WAIT;
          endcase
        GET_A:  r_state <= GET_B;
        GET_B:
          r_state <= w_is_cmp ? STATUS : ALU;
        ALU:    r_state <= WB_REG;
        STATUS: r_state <= WAIT;
        WB_REG: r_state <= WAIT;
        WB_IMM: r_state <= WAIT;
        default: r_state <= WAIT;
      endcase
    end
  end

  reg_seq_out #(
    .RW(RW),
    .VW(VW)
  ) u_out (
    .i_state    (r_state),
    .i_opcode   (opcode),
    .i_op       (op),
    .i_rn       (rn),
    .i_rd       (rd),
    .i_rm       (rm),
    .o_w        (w),
    .o_readnum  (readnum),
    .o_writenum (writenum),
    .o_write    (write),
    .o_loada    (loada),
    .o_loadb    (loadb),
    .o_loadc    (loadc),
    .o_loads    (loads),
    .o_asel     (asel),
    .o_vsel     (vsel)
  );

endmodule

// File: tb/tb_reg_seq.sv
// Scoreboard bench for reg_seq: driver queues the
// expected control pulses, monitor pops on each pulse.
module tb_reg_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic       w;
  logic [2:0] readnum, writenum;
  logic       write, loada, loadb, loadc, loads;
  logic       asel;
  logic [1:0] vsel;

  // en = {write, loada, loadb, loadc, loads}
  typedef struct packed {
    logic [4:0] en;
    logic [2:0] num;
    logic [1:0] vsel;
    logic       asel;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;

  reg_seq #(.RW(3), .VW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .opcode   (opcode),
    .op       (op),
    .rn       (rn),
    .rd       (rd),
    .rm       (rm),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .vsel     (vsel)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic push(input logic [4:0] en,
                      input logic [2:0] num,
                      input logic [1:0] vs,
                      input logic as);
    ev_t e;
    e.en = en; e.num = num; e.vsel = vs; e.asel = as;
    q.push_back(e);
  endtask

  // Monitor: every enable pulse must match the next queued event
  always @(negedge clk) begin
    logic [4:0] en;
    ev_t e;
    en = {write, loada, loadb, loadc, loads};
    if (rst_n === 1'b1 && en != 5'b0) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {27'b0, en}, 0);
      end else begin
        e = q.pop_front();
        check("enables", {27'b0, en}, {27'b0, e.en});
        if (en[3] || en[2])
          check("readnum", {29'b0, readnum}, {29'b0, e.num});
        if (en[4]) begin
          check("writenum", {29'b0, writenum}, {29'b0, e.num});
          check("vsel", {30'b0, vsel}, {30'b0, e.vsel});
        end
        if (en[1] || en[0])
          check("asel", {31'b0, asel}, {31'b0, e.asel});
      end
    end
  end

  task automatic run(input string nm,
                     input logic [2:0] a_opc,
                     input logic [1:0] a_op,
                     input logic [2:0] a_rn,
                     input logic [2:0] a_rd,
                     input logic [2:0] a_rm,
                     input int lat,
                     input bit spam);
    int n;
    bit done;
    @(negedge clk);
    opcode = a_opc; op = a_op;
    rn = a_rn; rd = a_rd; rm = a_rm;
    s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    n = 1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      n++;
      if (w) done = 1'b1;
      else if (spam) s = n[0];
    end
    s = 1'b0;
    if (!done) check({nm, "_timeout"}, 0, 1);
    else check({nm, "_latency"}, n, lat);
    @(posedge clk); #1;
    check({nm, "_stays_idle"}, {31'b0, w}, 1);
    check({nm, "_queue_empty"}, q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s = 1'b0;
    opcode = 3'b0; op = 2'b0;
    rn = 3'd0; rd = 3'd0; rm = 3'd0;
    #12;
    check("rst_w", {31'b0, w}, 1);
    check("rst_en",
          {27'b0, write, loada, loadb, loadc, loads}, 0);
    check("rst_readnum", {29'b0, readnum}, 0);
    check("rst_writenum", {29'b0, writenum}, 0);
    check("rst_asel", {31'b0, asel}, 0);
    check("rst_vsel", {30'b0, vsel}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_w", {31'b0, w}, 1);
    end

    // MOV R2,#imm
    push(5'b10000, 3'd2, 2'b10, 1'b0);
    run("movi_r2", 3'b110, 2'b10, 3'd2, 3'd0, 3'd0, 3, 0);

    // ADD R5,R1,R3
    push(5'b01000, 3'd1, 2'b00, 1'b0);
    push(5'b00100, 3'd3, 2'b00, 1'b0);
    push(5'b00010, 3'd0, 2'b00, 1'b0);
    push(5'b10000, 3'd5, 2'b00, 1'b0);
    run("add_r5", 3'b101, 2'b00, 3'd1, 3'd5, 3'd3, 6, 0);

    // CMP R4,R6
    push(5'b01000, 3'd4, 2'b00, 1'b0);
    push(5'b00100, 3'd6, 2'b00, 1'b0);
    push(5'b00001, 3'd0, 2'b00, 1'b0);
    run("cmp_r4_r6", 3'b101, 2'b01, 3'd4, 3'd0, 3'd6, 5, 0);

    // MVN R0,R7
    push(5'b00100, 3'd7, 2'b00, 1'b0);
    push(5'b00010, 3'd0, 2'b00, 1'b1);
    push(5'b10000, 3'd0, 2'b00, 1'b0);
    run("mvn_r0_r7", 3'b101, 2'b11, 3'd5, 3'd0, 3'd7, 5, 0);

    // MOV R1,R6
    push(5'b00100, 3'd6, 2'b00, 1'b0);
    push(5'b00010, 3'd0, 2'b00, 1'b1);
    push(5'b10000, 3'd1, 2'b00, 1'b0);
    run("movr_r1_r6", 3'b110, 2'b00, 3'd2, 3'd1, 3'd6, 5, 0);

    // AND R3,R3,R3 with s toggling while busy
    push(5'b01000, 3'd3, 2'b00, 1'b0);
    push(5'b00100, 3'd3, 2'b00, 1'b0);
    push(5'b00010, 3'd0, 2'b00, 1'b0);
    push(5'b10000, 3'd3, 2'b00, 1'b0);
    run("and_r3_spam", 3'b101, 2'b10, 3'd3, 3'd3, 3'd3, 6, 1);

    // Illegal codes: no pulse at all
    run("illegal_111", 3'b111, 2'b00, 3'd1, 3'd2, 3'd3, 2, 0);
    run("illegal_110_01", 3'b110, 2'b01, 3'd1, 3'd2, 3'd3, 2, 0);

    // ADD R5,R1,R3 cut by reset in its write-back cycle
    push(5'b01000, 3'd1, 2'b00, 1'b0);
    push(5'b00100, 3'd3, 2'b00, 1'b0);
    push(5'b00010, 3'd0, 2'b00, 1'b0);
    @(negedge clk);
    opcode = 3'b101; op = 2'b00;
    rn = 3'd1; rd = 3'd5; rm = 3'd3;
    s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("wb_write_before_rst", {31'b0, write}, 1);
    check("wb_writenum_before_rst", {29'b0, writenum}, 5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_write", {31'b0, write}, 0);
    check("rst_mid_w", {31'b0, w}, 1);
    check("rst_mid_writenum", {29'b0, writenum}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_w", {31'b0, w}, 1);
    check("post_rst_queue", q.size(), 0);

    push(5'b10000, 3'd2, 2'b10, 1'b0);
    run("movi_after_rst", 3'b110, 2'b10, 3'd2, 3'd0, 3'd0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
